// File: rtl/machinev_pkg.sv
// Shared types and constants for the MachineV boot-stage program loader.
package machinev_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LEN_HI  = 4'd1,
    LEN_LO  = 4'd2,
    DATA_HI = 4'd3,
    DATA_LO = 4'd4,
    ADDR    = 4'd5,
    DATA    = 4'd6,
    WRITE   = 4'd7,
    CHECK   = 4'd8,
    DONE    = 4'd9,
    ERROR   = 4'd10
  } loader_state_t;

  localparam int         BYTES_PER_WORD = 2;
  localparam logic [7:0] CKSUM_INIT     = 8'h00;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream handshake, memory strobes and status of the program loader.
interface program_loader_if #(
  parameter int ADDRESS_WIDTH = 12
) ();

  logic                   start;
  logic [7:0]             byte_in;
  logic                   byte_valid;
  logic                   byte_ready;
  logic                   mem_addr;
  logic                   mem_in;
  logic                   mem_write;
  logic                   cpu_hold;
  logic                   done;
  logic                   error;
  logic [ADDRESS_WIDTH:0] words_loaded;

  modport master (
    input  start, byte_in, byte_valid,
    output byte_ready, mem_addr, mem_in, mem_write, cpu_hold, done, error, words_loaded
  );

  modport slave (
    output start, byte_in, byte_valid,
    input  byte_ready, mem_addr, mem_in, mem_write, cpu_hold, done, error, words_loaded
  );

endinterface

// File: rtl/program_loader.sv
// Boot loader: parses a length/payload/checksum byte stream and writes the
// words into Memory over the shared Abus/Dbus while holding the core stalled.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// LEN_HI  | receive length high byte
// LEN_LO  | receive length low byte, range check
// DATA_HI | receive word high byte
// DATA_LO | receive word low byte
// ADDR    | drive Abus, pulse mem_addr
// DATA    | drive Dbus, pulse mem_in
// WRITE   | hold Dbus, pulse mem_write, advance address
// CHECK   | receive and compare checksum byte
// DONE    | load good, core released
// ERROR   | bad length or checksum, core held
module program_loader
  import machinev_pkg::*;
#(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 12,
  parameter int LOAD_BASE     = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  program_loader_if.master         ldr,
  inout  wire  [ADDRESS_WIDTH-1:0] Abus,
  inout  wire  [WORD_WIDTH-1:0]    Dbus
);

  localparam logic [3:0] S_IDLE    = IDLE;
  localparam logic [3:0] S_LEN_HI  = LEN_HI;
  localparam logic [3:0] S_LEN_LO  = LEN_LO;
  localparam logic [3:0] S_DATA_HI = DATA_HI;
  localparam logic [3:0] S_DATA_LO = DATA_LO;
  localparam logic [3:0] S_ADDR    = ADDR;
  localparam logic [3:0] S_DATA    = DATA;
  localparam logic [3:0] S_WRITE   = WRITE;
  localparam logic [3:0] S_CHECK   = CHECK;
  localparam logic [3:0] S_DONE    = DONE;
  localparam logic [3:0] S_ERROR   = ERROR;

  localparam logic [ADDRESS_WIDTH-1:0] BASE_ADDR = ADDRESS_WIDTH'(LOAD_BASE);
  // Largest length that fits between LOAD_BASE and the top of memory.
  localparam logic [16:0] LEN_LIMIT = 17'((1 << ADDRESS_WIDTH) - LOAD_BASE);

  logic [3:0]                    state, state_nx;
  logic                          byte_ready;
  logic [7:0]                    len_hi;
  logic [15:0]                   len;
  logic [7:0]                    byte_hi;
  logic [8*BYTES_PER_WORD-1:0]   word;
  logic [7:0]                    cksum;
  logic [ADDRESS_WIDTH-1:0]      addr;
  logic [ADDRESS_WIDTH:0]        words_loaded;
  logic [ADDRESS_WIDTH:0]        words_inc;
  logic [15:0]                   len_rx;
  logic                          take;
  logic                          ready_nx;

  assign take      = ldr.byte_valid && byte_ready;
  assign len_rx    = {len_hi, ldr.byte_in};
  assign words_inc = words_loaded + (ADDRESS_WIDTH+1)'(1);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (ldr.start) state_nx = S_LEN_HI;
      S_LEN_HI:  if (take) state_nx = S_LEN_LO;
      S_LEN_LO: begin
        if (take) begin
          if ({1'b0, len_rx} > LEN_LIMIT) state_nx = S_ERROR;
          else if (len_rx == 16'd0)       state_nx = S_CHECK;
          else                            state_nx = S_DATA_HI;
        end
      end
      S_DATA_HI: if (take) state_nx = S_DATA_LO;
      S_DATA_LO: if (take) state_nx = S_ADDR;
      S_ADDR:    state_nx = S_DATA;
      S_DATA:    state_nx = S_WRITE;
      S_WRITE:   state_nx = (17'(words_inc) == {1'b0, len}) ? S_CHECK : S_DATA_HI;
      S_CHECK: begin
        if (take) state_nx = (ldr.byte_in == cksum) ? S_DONE : S_ERROR;
      end
      default:   state_nx = S_IDLE;
    endcase
  end

  // byte_ready is registered from the next state so it is valid on state entry.
  always_comb begin
    ready_nx = 1'b0;
    case (state_nx)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: ready_nx = 1'b1;
      default: ready_nx = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= S_IDLE;
      byte_ready   <= 1'b0;
      len_hi       <= 8'h00;
      len          <= 16'h0000;
      byte_hi      <= 8'h00;
      word         <= '0;
      cksum        <= CKSUM_INIT;
      addr         <= BASE_ADDR;
      words_loaded <= '0;
    end else begin
      state      <= state_nx;
      byte_ready <= ready_nx;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (ldr.start) begin
            words_loaded <= '0;
            cksum        <= CKSUM_INIT;
            addr         <= BASE_ADDR;
          end
        end
        S_LEN_HI: if (take) len_hi <= ldr.byte_in;
        S_LEN_LO: if (take) len <= len_rx;
        S_DATA_HI: begin
          if (take) begin
            byte_hi <= ldr.byte_in;
            cksum   <= cksum ^ ldr.byte_in;
          end
        end
        S_DATA_LO: begin
          if (take) begin
            word  <= {byte_hi, ldr.byte_in};
            cksum <= cksum ^ ldr.byte_in;
          end
        end
        S_WRITE: begin
          addr         <= addr + ADDRESS_WIDTH'(1);
          words_loaded <= words_inc;
        end
        default: ;
      endcase
    end
  end

  assign ldr.byte_ready   = byte_ready;
  assign ldr.mem_addr     = (state == S_ADDR);
  assign ldr.mem_in       = (state == S_DATA);
  assign ldr.mem_write    = (state == S_WRITE);
  assign ldr.cpu_hold     = (state != S_DONE);
  assign ldr.done         = (state == S_DONE);
  assign ldr.error        = (state == S_ERROR);
  assign ldr.words_loaded = words_loaded;

  assign Abus = (state == S_ADDR) ? addr : {ADDRESS_WIDTH{1'bz}};
  assign Dbus = (state == S_DATA || state == S_WRITE) ? WORD_WIDTH'(word) : {WORD_WIDTH{1'bz}};

endmodule
